// File: rtl/clause_array_ctrl_pkg.sv
// rtl/clause_array_ctrl_pkg.sv - shared types and constants for the clause array sequencer
//
// Purpose: state encoding and counter sizing used by clause_array_ctrl and its
// row pointer. No ports.

package clause_array_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_BCP_PULSE = 3'd2,
    S_BCP_WAIT  = 3'd3,
    S_LEARNT    = 3'd4,
    S_BKT       = 3'd5,
    S_READ      = 3'd6
  } state_t;

  // Settle counter holds 0..SETTLE_CYCLES-1 with SETTLE_CYCLES up to 15.
  localparam int SETTLE_W = 4;

  localparam int DEF_NUM_CLAUSES = 8;
  localparam int ROW_BITS        = $clog2(DEF_NUM_CLAUSES);

  function automatic int row_bits(input int num_clauses);
    return $clog2(num_clauses);
  endfunction

endpackage

// File: rtl/clause_array_ctrl_if.sv
// rtl/clause_array_ctrl_if.sv - bus bundle between engine/array and the clause array sequencer
//
// Purpose: groups every non-clock signal of clause_array_ctrl.
//   master : engine + clause array side (drives the *_i signals)
//   slave  : clause_array_ctrl (drives the *_o signals)
// Groups: clause load stream (c_*), BCP/backtrack starts, learnt clause
// offer (learnt_*), readback stream (r_*), array control (wr/rd/clause/strobes),
// status (busy/done/sat/conflict/load_ovf).
// Optional: CLAUSE_ARRAY_CTRL_STATS_EN adds bcp_cnt_o / conflict_cnt_o.

interface clause_array_ctrl_if #(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_C_LEN = 4
);

  logic                     load_start_i;
  logic                     c_valid_i;
  logic                     c_ready_o;
  logic                     c_last_i;
  logic [NUM_VARS*2-1:0]    c_data_i;
  logic [WIDTH_C_LEN-1:0]   c_len_i;
  logic                     bcp_start_i;
  logic                     bkt_start_i;
  logic                     learnt_valid_i;
  logic                     learnt_ready_o;
  logic [NUM_VARS*2-1:0]    learnt_data_i;
  logic [WIDTH_C_LEN-1:0]   learnt_len_i;
  logic [NUM_CLAUSES-1:0]   learnt_idx_i;
  logic                     rd_start_i;
  logic                     r_valid_o;
  logic                     r_ready_i;
  logic [NUM_VARS*2-1:0]    r_data_o;
  logic [NUM_CLAUSES-1:0]   wr_o;
  logic [NUM_CLAUSES-1:0]   rd_o;
  logic [NUM_VARS*2-1:0]    clause_o;
  logic [WIDTH_C_LEN-1:0]   clause_len_o;
  logic [NUM_VARS*2-1:0]    clause_i;
  logic                     add_learntc_en_o;
  logic                     apply_impl_o;
  logic                     apply_bkt_o;
  logic                     all_c_sat_i;
  logic                     conflict_i;
  logic                     busy_o;
  logic                     done_o;
  logic                     sat_o;
  logic                     conflict_o;
  logic                     load_ovf_o;
`ifdef CLAUSE_ARRAY_CTRL_STATS_EN
  logic [15:0]              bcp_cnt_o;
  logic [15:0]              conflict_cnt_o;
`endif

  modport master (
    output load_start_i, c_valid_i, c_last_i, c_data_i, c_len_i,
           bcp_start_i, bkt_start_i,
           learnt_valid_i, learnt_data_i, learnt_len_i, learnt_idx_i,
           rd_start_i, r_ready_i, clause_i, all_c_sat_i, conflict_i,
    input  c_ready_o, learnt_ready_o, r_valid_o, r_data_o,
           wr_o, rd_o, clause_o, clause_len_o,
           add_learntc_en_o, apply_impl_o, apply_bkt_o,
           busy_o, done_o, sat_o, conflict_o, load_ovf_o
`ifdef CLAUSE_ARRAY_CTRL_STATS_EN
    , input bcp_cnt_o, conflict_cnt_o
`endif
  );

  modport slave (
    input  load_start_i, c_valid_i, c_last_i, c_data_i, c_len_i,
           bcp_start_i, bkt_start_i,
           learnt_valid_i, learnt_data_i, learnt_len_i, learnt_idx_i,
           rd_start_i, r_ready_i, clause_i, all_c_sat_i, conflict_i,
    output c_ready_o, learnt_ready_o, r_valid_o, r_data_o,
           wr_o, rd_o, clause_o, clause_len_o,
           add_learntc_en_o, apply_impl_o, apply_bkt_o,
           busy_o, done_o, sat_o, conflict_o, load_ovf_o
`ifdef CLAUSE_ARRAY_CTRL_STATS_EN
    , output bcp_cnt_o, conflict_cnt_o
`endif
  );

endinterface

// File: rtl/clause_array_ctrl_onehot_row_ptr.sv
// rtl/clause_array_ctrl_onehot_row_ptr.sv - one-hot row pointer shared by load and readback
//
// Purpose: NUM_CLAUSES-wide one-hot pointer starting at row 0.
//   clk, rst : clock, synchronous active-high reset (pointer -> row 0)
//   clr      : return pointer to row 0 (wins over adv)
//   adv      : shift to the next row; shifting past the last row gives all-zero
//   ptr      : current one-hot row
//   last     : pointer sits on row NUM_CLAUSES-1

module onehot_row_ptr
  import clause_array_ctrl_pkg::*;
#(
  parameter int NUM_CLAUSES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   adv,
  output logic [NUM_CLAUSES-1:0] ptr,
  output logic                   last
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= NUM_CLAUSES'(1);
    end else if (adv) begin
      ptr <= ptr << 1;
    end
  end

  assign last = ptr[NUM_CLAUSES-1];

endmodule

// File: rtl/clause_array_ctrl.sv
// rtl/clause_array_ctrl.sv - sequencer for one clause array bin (load, BCP, learnt insert, backtrack, readback)
//
// Purpose: sole driver of the clause array's wr/rd/control inputs, commanded by
// the SAT engine FSM through start strobes.
//   clk : clock
//   rst : synchronous active-high reset; aborts any operation
//   bus : clause_array_ctrl_if.slave (streams, array control, status)
// Array writes (wr_o, clause_o, clause_len_o) are registered, so a load
// handshake shows up on wr_o in the following cycle.
// Optional: define CLAUSE_ARRAY_CTRL_STATS_EN for saturating BCP/conflict counters.

module clause_array_ctrl
  import clause_array_ctrl_pkg::*;
#(
  parameter int NUM_CLAUSES   = 8,
  parameter int NUM_VARS      = 8,
  parameter int WIDTH_C_LEN   = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  clause_array_ctrl_if.slave bus
);

  localparam int N = NUM_CLAUSES;
  localparam int D = NUM_VARS * 2;
  localparam logic [N-1:0] LOWER_HALF = {{(N - N/2){1'b0}}, {(N/2){1'b1}}};
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t state_q, state_d;

  logic [N-1:0] ptr;
  logic ptr_last, ptr_clr, ptr_adv;

  logic [N-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [D-1:0] clause_q, clause_d;
  logic [WIDTH_C_LEN-1:0] len_q, len_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic add_q, add_d, impl_q, impl_d, bkt_q, bkt_d, done_q, done_d;
  logic rvalid_q, rvalid_d, sat_q, sat_d, conf_q, conf_d;
  logic ovf_q, ovf_d, full_q, full_d, busy_q;
  logic learnt_ok;

  onehot_row_ptr #(.NUM_CLAUSES(N)) u_ptr (
    .clk  (clk),
    .rst  (rst),
    .clr  (ptr_clr),
    .adv  (ptr_adv),
    .ptr  (ptr),
    .last (ptr_last)
  );

  // Learnt clauses may only replace rows in the upper half; anything else is dropped.
  assign learnt_ok = $onehot(bus.learnt_idx_i) && ((bus.learnt_idx_i & LOWER_HALF) == '0);

  always_comb begin
    state_d  = state_q;
    wr_d     = '0;
    rd_d     = rd_q;
    clause_d = clause_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    add_d    = 1'b0;
    impl_d   = 1'b0;
    bkt_d    = 1'b0;
    done_d   = 1'b0;
    rvalid_d = rvalid_q;
    sat_d    = sat_q;
    conf_d   = conf_q;
    ovf_d    = ovf_q;
    full_d   = full_q;
    ptr_clr  = 1'b0;
    ptr_adv  = 1'b0;

    // After a load that filled every row, any further offer is an overflow.
    if (state_q != S_LOAD && full_q && bus.c_valid_i) ovf_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.load_start_i) begin
          state_d = S_LOAD;
          ptr_clr = 1'b1;
          ovf_d   = 1'b0;
          full_d  = 1'b0;
        end else if (bus.learnt_valid_i) begin
          state_d  = S_LEARNT;
          wr_d     = learnt_ok ? bus.learnt_idx_i : '0;
          add_d    = learnt_ok;
          clause_d = bus.learnt_data_i;
          len_d    = bus.learnt_len_i;
        end else if (bus.bkt_start_i) begin
          state_d = S_BKT;
          bkt_d   = 1'b1;
        end else if (bus.bcp_start_i) begin
          state_d = S_BCP_PULSE;
          impl_d  = 1'b1;
        end else if (bus.rd_start_i) begin
          state_d  = S_READ;
          ptr_clr  = 1'b1;
          rd_d     = N'(1);
          rvalid_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (bus.c_valid_i) begin
          wr_d     = ptr;
          clause_d = bus.c_data_i;
          len_d    = bus.c_len_i;
          ptr_adv  = 1'b1;
          if (bus.c_last_i || ptr_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            ptr_clr = 1'b1;
            full_d  = ptr_last;
          end
        end
      end
      S_BCP_PULSE: begin
        state_d = S_BCP_WAIT;
        cnt_d   = '0;
      end
      S_BCP_WAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          sat_d   = bus.all_c_sat_i;
          conf_d  = bus.conflict_i;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LEARNT: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_BKT: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        sat_d   = 1'b0;
        conf_d  = 1'b0;
      end
      S_READ: begin
        if (bus.r_ready_i) begin
          if (ptr_last) begin
            state_d  = S_IDLE;
            rd_d     = '0;
            rvalid_d = 1'b0;
            done_d   = 1'b1;
            ptr_clr  = 1'b1;
          end else begin
            rd_d    = {ptr[N-2:0], 1'b0};
            ptr_adv = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_q     <= '0;
      rd_q     <= '0;
      clause_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      add_q    <= 1'b0;
      impl_q   <= 1'b0;
      bkt_q    <= 1'b0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      sat_q    <= 1'b0;
      conf_q   <= 1'b0;
      ovf_q    <= 1'b0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      clause_q <= clause_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      add_q    <= add_d;
      impl_q   <= impl_d;
      bkt_q    <= bkt_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      sat_q    <= sat_d;
      conf_q   <= conf_d;
      ovf_q    <= ovf_d;
      full_q   <= full_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign bus.c_ready_o        = (state_q == S_LOAD);
  assign bus.learnt_ready_o   = (state_q == S_LEARNT);
  assign bus.r_valid_o        = rvalid_q;
  assign bus.r_data_o         = rvalid_q ? bus.clause_i : '0;
  assign bus.wr_o             = wr_q;
  assign bus.rd_o             = rd_q;
  assign bus.clause_o         = clause_q;
  assign bus.clause_len_o     = len_q;
  assign bus.add_learntc_en_o = add_q;
  assign bus.apply_impl_o     = impl_q;
  assign bus.apply_bkt_o      = bkt_q;
  assign bus.busy_o           = busy_q;
  assign bus.done_o           = done_q;
  assign bus.sat_o            = sat_q;
  assign bus.conflict_o       = conf_q;
  assign bus.load_ovf_o       = ovf_q;

`ifdef CLAUSE_ARRAY_CTRL_STATS_EN
  logic [15:0] bcp_cnt_q, conf_cnt_q;
  logic load_go, bcp_fin;

  assign load_go = (state_q == S_IDLE) && bus.load_start_i;
  assign bcp_fin = (state_q == S_BCP_WAIT) && (cnt_q == SETTLE_LAST);

  always_ff @(posedge clk) begin
    if (rst || load_go) begin
      bcp_cnt_q  <= '0;
      conf_cnt_q <= '0;
    end else if (bcp_fin) begin
      if (bcp_cnt_q != 16'hFFFF) bcp_cnt_q <= bcp_cnt_q + 16'd1;
      if (bus.conflict_i && conf_cnt_q != 16'hFFFF) conf_cnt_q <= conf_cnt_q + 16'd1;
    end
  end

  assign bus.bcp_cnt_o      = bcp_cnt_q;
  assign bus.conflict_cnt_o = conf_cnt_q;
`endif

endmodule

// File: tb/tb_clause_array_ctrl.sv
// tb/tb_clause_array_ctrl.sv - self-checking bench for clause_array_ctrl

module tb_clause_array_ctrl;

  localparam int NC = 8;
  localparam int NV = 8;
  localparam int WL = 4;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clause_array_ctrl_if #(.NUM_CLAUSES(NC), .NUM_VARS(NV), .WIDTH_C_LEN(WL)) bus ();

  clause_array_ctrl #(
    .NUM_CLAUSES(NC), .NUM_VARS(NV), .WIDTH_C_LEN(WL), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  // Clause array stand-in: rows written on wr_o, read combinationally on rd_o.
  logic [2*NV-1:0] mem     [NC] = '{default: '0};
  // Expected row contents, tracked from what the bench offered.
  logic [2*NV-1:0] exp_mem [NC] = '{default: '0};

  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) if (bus.wr_o[i]) mem[i] <= bus.clause_o;
  end

  always_comb begin
    bus.clause_i = '0;
    for (int i = 0; i < NC; i++) if (bus.rd_o[i]) bus.clause_i = bus.clause_i | mem[i];
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ((|bus.wr_o && |bus.rd_o) || (bus.apply_impl_o && bus.apply_bkt_o)) begin
        failures++;
        $display("FAIL exclusive wr=%h rd=%h impl=%b bkt=%b", bus.wr_o, bus.rd_o, bus.apply_impl_o, bus.apply_bkt_o);
      end
    end
  end

  task automatic clear_inputs();
    bus.load_start_i = 0; bus.c_valid_i = 0; bus.c_last_i = 0; bus.c_data_i = '0; bus.c_len_i = '0;
    bus.bcp_start_i = 0; bus.bkt_start_i = 0; bus.learnt_valid_i = 0; bus.learnt_data_i = '0;
    bus.learnt_len_i = '0; bus.learnt_idx_i = '0; bus.rd_start_i = 0; bus.r_ready_i = 0;
    bus.all_c_sat_i = 0; bus.conflict_i = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    repeat (3) @(negedge clk);
    rst = 0;
    checks++;
    if ({bus.busy_o, bus.done_o, bus.c_ready_o, bus.learnt_ready_o, bus.r_valid_o, bus.apply_impl_o,
         bus.apply_bkt_o, bus.add_learntc_en_o, bus.sat_o, bus.conflict_o, bus.load_ovf_o} !== 11'd0) begin
      failures++; $display("FAIL reset_flags got nonzero busy=%b done=%b", bus.busy_o, bus.done_o);
    end
    checks++;
    if (bus.wr_o !== '0 || bus.rd_o !== '0) begin
      failures++; $display("FAIL reset_rows wr=%h rd=%h exp=0", bus.wr_o, bus.rd_o);
    end
    checks++;
    if (bus.clause_o !== '0 || bus.clause_len_o !== '0 || bus.r_data_o !== '0) begin
      failures++; $display("FAIL reset_data clause=%h len=%h rdata=%h exp=0", bus.clause_o, bus.clause_len_o, bus.r_data_o);
    end
  endtask

  task automatic test_load(input int n, input bit gaps);
    logic [2*NV-1:0] d;
    logic [WL-1:0] l;
    logic [NC-1:0] exp_wr;
    bus.load_start_i = 1;
    @(negedge clk);
    bus.load_start_i = 0;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.c_valid_i = 0;
        @(negedge clk);
        checks++;
        if (bus.wr_o !== '0) begin failures++; $display("FAIL load_gap_wr got=%h exp=0", bus.wr_o); end
      end
      d = (2*NV)'($urandom); l = WL'($urandom);
      bus.c_valid_i = 1; bus.c_data_i = d; bus.c_len_i = l; bus.c_last_i = (k == n - 1);
      checks++;
      if (bus.c_ready_o !== 1'(k < NC)) begin
        failures++; $display("FAIL load_ready k=%0d got=%b exp=%b", k, bus.c_ready_o, k < NC);
      end
      @(negedge clk);
      if (k < NC) begin
        exp_mem[k] = d;
        exp_wr = NC'(1) << k;
        checks++;
        if (bus.wr_o !== exp_wr) begin failures++; $display("FAIL load_wr k=%0d got=%h exp=%h", k, bus.wr_o, exp_wr); end
        checks++;
        if (bus.clause_o !== d || bus.clause_len_o !== l) begin
          failures++; $display("FAIL load_data k=%0d got=%h/%h exp=%h/%h", k, bus.clause_o, bus.clause_len_o, d, l);
        end
        checks++;
        if (bus.done_o !== 1'(k == n - 1 || k == NC - 1)) begin
          failures++; $display("FAIL load_done k=%0d got=%b", k, bus.done_o);
        end
      end else begin
        checks++;
        if (bus.load_ovf_o !== 1'b1 || bus.wr_o !== '0) begin
          failures++; $display("FAIL load_ovf_set got=%b wr=%h exp=1/0", bus.load_ovf_o, bus.wr_o);
        end
      end
    end
    bus.c_valid_i = 0; bus.c_last_i = 0;
    checks++;
    if (bus.load_ovf_o !== 1'(n > NC) || bus.busy_o !== 1'b0) begin
      failures++; $display("FAIL load_end ovf=%b busy=%b exp=%b/0", bus.load_ovf_o, bus.busy_o, n > NC);
    end
  endtask

  task automatic test_bcp(input bit s, input bit c);
    int lat = -1;
    int pulses = 0;
    bus.bcp_start_i = 1; bus.all_c_sat_i = ~s; bus.conflict_i = ~c;
    for (int cyc = 1; cyc <= 12 && lat < 0; cyc++) begin
      @(negedge clk);
      bus.bcp_start_i = 0;
      if (bus.apply_impl_o) begin
        pulses++;
        checks++;
        if (cyc != 1) begin failures++; $display("FAIL bcp_impl_cycle got=%0d exp=1", cyc); end
      end
      if (bus.done_o) lat = cyc;
      // Only the last settle cycle carries the true flags.
      bus.all_c_sat_i = (cyc == SETTLE + 1) ? s : ~s;
      bus.conflict_i  = (cyc == SETTLE + 1) ? c : ~c;
    end
    bus.all_c_sat_i = 0; bus.conflict_i = 0;
    checks++;
    if (lat != SETTLE + 2) begin failures++; $display("FAIL bcp_latency got=%0d exp=%0d", lat, SETTLE + 2); end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL bcp_impl_pulses got=%0d exp=1", pulses); end
    checks++;
    if (bus.sat_o !== s || bus.conflict_o !== c) begin
      failures++; $display("FAIL bcp_flags got=%b/%b exp=%b/%b", bus.sat_o, bus.conflict_o, s, c);
    end
    checks++;
    if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL bcp_busy got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_learnt(input logic [NC-1:0] idx, input logic [WL-1:0] len);
    logic [2*NV-1:0] d;
    bit ok;
    d = (2*NV)'($urandom);
    ok = ($countones(idx) == 1);
    bus.learnt_valid_i = 1; bus.learnt_idx_i = idx; bus.learnt_data_i = d; bus.learnt_len_i = len;
    @(negedge clk);
    checks++;
    if (bus.learnt_ready_o !== 1'b1) begin failures++; $display("FAIL learnt_ready got=%b exp=1", bus.learnt_ready_o); end
    checks++;
    if (bus.wr_o !== (ok ? idx : '0)) begin
      failures++; $display("FAIL learnt_wr idx=%h got=%h exp=%h", idx, bus.wr_o, ok ? idx : '0);
    end
    if (ok) begin
      checks++;
      if (bus.add_learntc_en_o !== 1'b1 || bus.clause_o !== d || bus.clause_len_o !== len) begin
        failures++; $display("FAIL learnt_insert add=%b got=%h/%h exp=%h/%h", bus.add_learntc_en_o, bus.clause_o, bus.clause_len_o, d, len);
      end
      for (int i = 0; i < NC; i++) if (idx[i]) exp_mem[i] = d;
    end
    bus.learnt_valid_i = 0;
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b1 || bus.wr_o !== '0 || bus.add_learntc_en_o !== 1'b0) begin
      failures++; $display("FAIL learnt_done done=%b wr=%h add=%b exp=1/0/0", bus.done_o, bus.wr_o, bus.add_learntc_en_o);
    end
  endtask

  task automatic test_bkt();
    bus.bkt_start_i = 1;
    @(negedge clk);
    bus.bkt_start_i = 0;
    checks++;
    if (bus.apply_bkt_o !== 1'b1 || bus.done_o !== 1'b0) begin
      failures++; $display("FAIL bkt_pulse got=%b done=%b exp=1/0", bus.apply_bkt_o, bus.done_o);
    end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b1 || bus.apply_bkt_o !== 1'b0 || bus.sat_o !== 1'b0 || bus.conflict_o !== 1'b0) begin
      failures++; $display("FAIL bkt_done done=%b bkt=%b sat=%b conf=%b exp=1/0/0/0", bus.done_o, bus.apply_bkt_o, bus.sat_o, bus.conflict_o);
    end
  endtask

  task automatic test_read(input int stall_row);
    int row = 0;
    int stall = 0;
    logic [NC-1:0] exp_rd;
    bus.rd_start_i = 1; bus.r_ready_i = 0;
    for (int cyc = 0; cyc < 40 && row < NC; cyc++) begin
      @(negedge clk);
      bus.rd_start_i = 0;
      exp_rd = NC'(1) << row;
      checks++;
      if (bus.r_valid_o !== 1'b1 || bus.rd_o !== exp_rd || bus.done_o !== 1'b0) begin
        failures++; $display("FAIL read_row row=%0d valid=%b rd=%h exp=%h done=%b", row, bus.r_valid_o, bus.rd_o, exp_rd, bus.done_o);
      end
      checks++;
      if (bus.r_data_o !== exp_mem[row]) begin
        failures++; $display("FAIL read_data row=%0d got=%h exp=%h", row, bus.r_data_o, exp_mem[row]);
      end
      if (row == stall_row && stall < 3) begin
        bus.r_ready_i = 0; stall++;
      end else begin
        bus.r_ready_i = 1; row++;
      end
    end
    checks++;
    if (row != NC) begin failures++; $display("FAIL read_timeout rows=%0d exp=%0d", row, NC); end
    @(negedge clk);
    bus.r_ready_i = 0;
    checks++;
    if (bus.done_o !== 1'b1 || bus.r_valid_o !== 1'b0 || bus.rd_o !== '0 || bus.busy_o !== 1'b0) begin
      failures++; $display("FAIL read_end done=%b valid=%b rd=%h busy=%b exp=1/0/0/0", bus.done_o, bus.r_valid_o, bus.rd_o, bus.busy_o);
    end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b0) begin failures++; $display("FAIL read_done_once got=%b exp=0", bus.done_o); end
  endtask

  task automatic test_read_reset();
    logic [NC-1:0] exp_rd;
    bus.rd_start_i = 1; bus.r_ready_i = 1;
    for (int row = 0; row < 4; row++) begin
      @(negedge clk);
      bus.rd_start_i = 0;
      exp_rd = NC'(1) << row;
      checks++;
      if (bus.rd_o !== exp_rd) begin failures++; $display("FAIL rst_read_row row=%0d got=%h exp=%h", row, bus.rd_o, exp_rd); end
    end
    rst = 1; bus.r_ready_i = 0;
    @(negedge clk);
    rst = 0;
    checks++;
    if (bus.rd_o !== '0 || bus.r_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      failures++; $display("FAIL rst_mid_read rd=%h valid=%b busy=%b done=%b exp=0", bus.rd_o, bus.r_valid_o, bus.busy_o, bus.done_o);
    end
  endtask

  task automatic test_priority();
    logic [2*NV-1:0] d;
    bus.load_start_i = 1; bus.learnt_valid_i = 1; bus.learnt_idx_i = 8'h80;
    bus.bkt_start_i = 1; bus.bcp_start_i = 1; bus.rd_start_i = 1;
    @(negedge clk);
    bus.load_start_i = 0;
    checks++;
    if (bus.c_ready_o !== 1'b1 || bus.add_learntc_en_o || bus.apply_bkt_o || bus.apply_impl_o || bus.r_valid_o) begin
      failures++; $display("FAIL prio_load ready=%b add=%b bkt=%b impl=%b rv=%b", bus.c_ready_o, bus.add_learntc_en_o, bus.apply_bkt_o, bus.apply_impl_o, bus.r_valid_o);
    end
    // Starts seen while loading must be dropped.
    d = (2*NV)'($urandom);
    bus.c_valid_i = 1; bus.c_data_i = d; bus.c_last_i = 1;
    @(negedge clk);
    bus.c_valid_i = 0; bus.c_last_i = 0;
    bus.learnt_valid_i = 0; bus.bkt_start_i = 0; bus.bcp_start_i = 0; bus.rd_start_i = 0;
    exp_mem[0] = d;
    checks++;
    if (bus.wr_o !== 8'h01 || bus.done_o !== 1'b1) begin failures++; $display("FAIL prio_load_done wr=%h done=%b", bus.wr_o, bus.done_o); end
    @(negedge clk);
    checks++;
    if (bus.busy_o || bus.apply_impl_o || bus.apply_bkt_o || bus.add_learntc_en_o || bus.r_valid_o) begin
      failures++; $display("FAIL busy_start_queued busy=%b impl=%b bkt=%b", bus.busy_o, bus.apply_impl_o, bus.apply_bkt_o);
    end
    d = (2*NV)'($urandom);
    bus.learnt_valid_i = 1; bus.learnt_data_i = d; bus.bkt_start_i = 1; bus.bcp_start_i = 1; bus.rd_start_i = 1;
    @(negedge clk);
    bus.learnt_valid_i = 0;
    exp_mem[7] = d;
    checks++;
    if (bus.add_learntc_en_o !== 1'b1 || bus.apply_bkt_o || bus.apply_impl_o || bus.r_valid_o) begin
      failures++; $display("FAIL prio_learnt add=%b bkt=%b impl=%b", bus.add_learntc_en_o, bus.apply_bkt_o, bus.apply_impl_o);
    end
    @(negedge clk);
    @(negedge clk);
    bus.bkt_start_i = 0;
    checks++;
    if (bus.apply_bkt_o !== 1'b1 || bus.apply_impl_o || bus.r_valid_o) begin
      failures++; $display("FAIL prio_bkt bkt=%b impl=%b rv=%b", bus.apply_bkt_o, bus.apply_impl_o, bus.r_valid_o);
    end
    @(negedge clk);
    @(negedge clk);
    bus.bcp_start_i = 0; bus.rd_start_i = 0;
    checks++;
    if (bus.apply_impl_o !== 1'b1 || bus.r_valid_o) begin
      failures++; $display("FAIL prio_bcp impl=%b rv=%b", bus.apply_impl_o, bus.r_valid_o);
    end
    repeat (SETTLE + 2) @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL prio_bcp_end busy=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_random_ops(input int iters);
    int op, a, b;
    logic [NC-1:0] idx;
    for (int it = 0; it < iters; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: test_load($urandom_range(1, NC + 2), 1'b1);
        1: test_bcp(1'($urandom), 1'($urandom));
        2: begin
          a = $urandom_range(NC/2, NC - 1);
          b = $urandom_range(NC/2, NC - 1);
          case ($urandom_range(0, 2))
            0: idx = NC'(1) << a;
            1: idx = '0;
            default: idx = (NC'(1) << a) | (NC'(1) << ((a == b) ? ((a == NC - 1) ? NC/2 : a + 1) : b));
          endcase
          test_learnt(idx, WL'($urandom));
        end
        3: test_bkt();
        default: test_read($urandom_range(0, NC));
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_load(5, 1'b0);
    test_load(9, 1'b0);
    test_bcp(1'b1, 1'b0);
    test_bcp(1'b0, 1'b1);
    test_bcp(1'($urandom), 1'($urandom));
    test_learnt(8'h40, 4'd3);
    test_learnt(8'h30, 4'd5);
    test_learnt(8'h00, 4'd1);
    test_bcp(1'b1, 1'b1);
    test_bkt();
    test_read(2);
    test_priority();
    test_random_ops(25);
    test_read_reset();
    test_read(NC);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
